rr_reg_arbiter: RTL and testbench
=================================

RR_REG_ARBITER -- requirements
Module: rr_reg_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter DW, default 8, width of the shared register.
REQ-003 SHALL have parameter HOLD, default 2, number of cycles the resource stays occupied after each write (minimum 1).
REQ-004 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-005 SHALL have port rst, input, 1, the reset; it is asynchronous and active-low.
REQ-006 SHALL have port req, input, NREQ, request vector; bit i belongs to requester i.
REQ-007 SHALL have port wdata, input, NREQ*DW, flattened write data; requester i owns bits [i*DW +: DW].
REQ-008 SHALL have port gnt, output, NREQ, one-hot grant, registered.
REQ-009 SHALL have port owner, output, clog2(NREQ), index of the last granted requester.
REQ-010 SHALL have port q, output, DW, the shared register contents.
REQ-011 SHALL have port q_valid, output, 1, single-cycle pulse marking that q was updated.
REQ-012 SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-013 SHALL implement an FSM with three states: IDLE, GRANT, HOLD.
REQ-014 IDLE: with req==0, SHALL stay in IDLE with gnt==0.
REQ-015 IDLE: with req!=0, SHALL select k, the first set req bit searching from (last+1) mod NREQ upward with wrap-around.
REQ-016 On that same edge, SHALL set gnt to onehot(k), owner to k and last to k, and enter GRANT.
REQ-017 GRANT lasts exactly one cycle; on the next edge SHALL load q with wdata[k], pulse q_valid for one cycle, clear gnt, load the hold counter with HOLD-1 and enter HOLD.
REQ-018 The write in GRANT SHALL be committed even if req[k] deasserts during GRANT; wdata is sampled at the GRANT-exit edge.
REQ-019 HOLD: SHALL decrement the counter each cycle and enter IDLE on the edge where the counter is 0; no arbitration occurs in HOLD.
REQ-020 Minimum spacing between successive grants SHALL be HOLD+2 cycles.
REQ-021 gnt SHALL never have more than one bit set, and SHALL be nonzero only in GRANT.
REQ-022 q SHALL hold its value except at the GRANT-exit edge.
REQ-023 A requester whose req is set continuously SHALL be granted within NREQ arbitration rounds (starvation-free).
REQ-024 owner SHALL retain the last granted index while in IDLE and HOLD.

Reset
REQ-025 rst low SHALL asynchronously force: state=IDLE, gnt=0, q=0, q_valid=0, owner=0, hold counter=0, last=NREQ-1.
REQ-026 With last=NREQ-1 after reset, requester 0 SHALL win the first arbitration.
REQ-027 Reset asserted in GRANT or HOLD SHALL abort the pending write; q reads 0 and no q_valid pulse is produced.
REQ-028 Reset deassertion SHALL take effect on the first rising clk edge after rst goes high.

Structure
REQ-029 A shared package SHALL hold the FSM state typedef (2-bit encoding: IDLE=0, GRANT=1, HOLD=2) and the defaults for NREQ, DW and HOLD.
REQ-030 The shared register SHALL be a separate sub-module, dffe_async_rst_n: a DW-wide D register with enable and asynchronous active-low reset to 0, instantiated once.
REQ-031 The round-robin selection SHALL be combinational logic inside rr_reg_arbiter; gnt, owner, q_valid and busy SHALL be registered.

Verification
REQ-032 Reset then req=4'b0001, wdata[0]=8'hA5 -> gnt=0001 for one cycle, then q=8'hA5 with q_valid pulse, busy high for HOLD+1 cycles.
REQ-033 req=4'b1111 held, wdata[i]=8'h10+i -> grant order 0,1,2,3,0, grants spaced exactly 4 cycles apart (HOLD=2), q sequence 10,11,12,13,10.
REQ-034 After owner=2, req=4'b0101 -> next grant goes to 0 via wrap-around, then to 2.
REQ-035 req[1] dropped during GRANT with wdata[1]=8'h3C -> q=8'h3C still written and q_valid pulses.
REQ-036 rst asserted low mid-HOLD after a write of 8'hFF -> q=0, gnt=0 and busy=0 immediately (before the next edge); after release, req=4'b1000 -> requester 3 is granted.
REQ-037 Random req/wdata for 10k cycles -> assertions hold: gnt one-hot-or-zero, q changes only on q_valid, no requester is starved beyond NREQ grants.

Source files
------------

// File: rtl/rr_reg_arbiter_pkg.sv
// Shared types and defaults for the round-robin register arbiter.
// FSM state encoding plus parameter defaults used by the top level.
package rr_reg_arbiter_pkg;

    localparam int NREQ_DEF = 4;
    localparam int DW_DEF   = 8;
    localparam int HOLD_DEF = 2;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_GRANT = 2'd1;
    localparam state_t S_HOLD  = 2'd2;

endpackage

// File: rtl/dffe_async_rst_n.sv
// DW-wide D register with enable.
// Asynchronous active-low reset clears it to zero.
module dffe_async_rst_n #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter guarding one shared register.
// Grant for one cycle, write on GRANT exit, then stay busy for HOLD cycles.
module rr_reg_arbiter
    import rr_reg_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int DW   = DW_DEF,
    parameter int HOLD = HOLD_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*DW-1:0]      wdata,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic [DW-1:0]           q,
    output logic                    q_valid,
    output logic                    busy
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

    state_t          state;
    logic [IW-1:0]   last;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   cand;
    logic            found;
    logic [CW-1:0]   cnt;
    logic [DW-1:0]   wsel;
    logic            wen;

    // Search starts just after the previous winner and wraps around.
    always_comb begin
        pick  = '0;
        cand  = '0;
        found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = IW'((int'(last) + i) % NREQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign wsel = DW'(wdata >> (int'(owner) * DW));
    assign wen  = (state == S_GRANT);

    dffe_async_rst_n #(
        .DW(DW)
    ) u_qreg (
        .clk(clk),
        .rst(rst),
        .en (wen),
        .d  (wsel),
        .q  (q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            gnt     <= '0;
            owner   <= '0;
            last    <= IW'(NREQ - 1);
            cnt     <= '0;
            q_valid <= 1'b0;
            busy    <= 1'b0;
        end else begin
            q_valid <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (found) begin
                        gnt   <= NREQ'(1) << pick;
                        owner <= pick;
                        last  <= pick;
                        state <= S_GRANT;
                        busy  <= 1'b1;
                    end
                end
                S_GRANT: begin
                    gnt     <= '0;
                    q_valid <= 1'b1;
                    cnt     <= CW'(HOLD - 1);
                    state   <= S_HOLD;
                end
                S_HOLD: begin
                    if (cnt == '0) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    gnt   <= '0;
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Scoreboard bench for rr_reg_arbiter: directed vectors plus a random soak.
// Stimulus queues expected grants; a negedge monitor pops and compares.
module tb_rr_reg_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int HOLD = 2;

    typedef struct {
        int         idx;
        logic [7:0] d;
    } exp_t;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [NREQ*DW-1:0]   wdata;
    logic [NREQ-1:0]      gnt;
    logic [1:0]           owner;
    logic [DW-1:0]        q;
    logic                 q_valid;
    logic                 busy;

    exp_t sb[$];
    int   gtimes[$];
    int   checks = 0;
    int   fails = 0;
    int   cyc = 0;
    int   gcount = 0;
    bit   rnd = 0;

    rr_reg_arbiter #(
        .NREQ(NREQ),
        .DW  (DW),
        .HOLD(HOLD)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .wdata  (wdata),
        .gnt    (gnt),
        .owner  (owner),
        .q      (q),
        .q_valid(q_valid),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    function automatic bit bit_of(input logic [NREQ-1:0] v, input int i);
        logic [NREQ-1:0] s;
        s = v >> i;
        return s[0];
    endfunction

    function automatic logic [7:0] byte_of(input logic [NREQ*DW-1:0] v,
                                           input int i);
        logic [NREQ*DW-1:0] s;
        s = v >> (i * DW);
        return s[7:0];
    endfunction

    function automatic int rr_pick(input int l, input logic [NREQ-1:0] r);
        for (int k = 1; k <= NREQ; k++)
            if (bit_of(r, (l + k) % NREQ)) return (l + k) % NREQ;
        return -1;
    endfunction

    // Monitor: invariants every cycle, scoreboard on gnt / q_valid.
    int              model_last = NREQ - 1;
    logic [7:0]      prev_q = '0;
    logic [NREQ-1:0] prev_req = '0;
    int              waitc[NREQ];
    int              last_g = -1;

    always @(negedge clk) begin
        if (!rst) begin
            model_last = NREQ - 1;
            prev_q     = '0;
            prev_req   = '0;
            last_g     = -1;
            for (int i = 0; i < NREQ; i++) waitc[i] = 0;
        end else begin
            chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            if (!q_valid) chk("q_stable", 32'(q), 32'(prev_q));
            if (gnt != '0) begin
                int g;
                gcount++;
                gtimes.push_back(cyc);
                if (last_g >= 0)
                    chk("grant_spacing", 32'(cyc - last_g >= HOLD + 2), 32'd1);
                last_g = cyc;
                if (rnd) begin
                    exp_t e;
                    e.idx = rr_pick(model_last, prev_req);
                    e.d   = byte_of(wdata, e.idx);
                    sb.push_back(e);
                end
                if (sb.size() == 0) begin
                    chk("unexpected_grant", 32'(gnt), 32'd0);
                    g = model_last;
                end else begin
                    g = sb[0].idx;
                    chk("gnt", 32'(gnt), 32'(NREQ'(1) << g));
                    chk("owner", 32'(owner), 32'(g));
                    model_last = g;
                end
                for (int i = 0; i < NREQ; i++) begin
                    if (i == g) waitc[i] = 0;
                    else if (bit_of(prev_req, i)) waitc[i]++;
                    chk("no_starve", 32'(waitc[i] <= NREQ), 32'd1);
                end
            end
            if (q_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_q_valid", 32'(q_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("q_data", 32'(q), 32'(e.d));
                end
            end
            prev_q   = q;
            prev_req = req;
            for (int i = 0; i < NREQ; i++)
                if (!bit_of(req, i)) waitc[i] = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int i, input logic [7:0] d);
        exp_t e;
        e.idx = i;
        e.d   = d;
        sb.push_back(e);
    endtask

    task automatic wait_grants(input int n, input int budget);
        int tgt;
        tgt = gcount + n;
        for (int k = 0; k < budget; k++) begin
            if (gcount >= tgt) return;
            tick();
        end
        chk("grant_timeout", 32'(gcount), 32'(tgt));
    endtask

    task automatic wait_gnt(input int budget);
        for (int k = 0; k < budget; k++) begin
            if (gnt != '0) return;
            tick();
        end
        chk("gnt_timeout", 32'(gnt), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        sb.delete();
        repeat (2) tick();
        rst = 1'b1;
    endtask

    initial begin
        int hold_cnt;
        rst   = 1'b0;
        req   = '0;
        wdata = '0;
        repeat (3) tick();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_q", 32'(q), 32'd0);
        chk("rst_q_valid", 32'(q_valid), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        tick();

        // Single write from requester 0
        push(0, 8'hA5);
        wdata = 32'h000000A5;
        req   = 4'b0001;
        tick();
        chk("w1_gnt", 32'(gnt), 32'h1);
        chk("w1_busy_g", 32'(busy), 32'd1);
        req = '0;
        tick();
        chk("w1_gnt_clr", 32'(gnt), 32'd0);
        chk("w1_q", 32'(q), 32'hA5);
        chk("w1_qv", 32'(q_valid), 32'd1);
        chk("w1_busy_h0", 32'(busy), 32'd1);
        tick();
        chk("w1_qv_pulse", 32'(q_valid), 32'd0);
        chk("w1_busy_h1", 32'(busy), 32'd1);
        tick();
        chk("w1_idle", 32'(busy), 32'd0);
        chk("w1_owner_keep", 32'(owner), 32'd0);
        repeat (2) tick();

        // Full contention from a fresh reset
        do_reset();
        tick();
        gtimes.delete();
        wdata = 32'h13121110;
        push(0, 8'h10);
        push(1, 8'h11);
        push(2, 8'h12);
        push(3, 8'h13);
        push(0, 8'h10);
        req = 4'b1111;
        wait_grants(5, 40);
        req = '0;
        repeat (6) tick();
        chk("rr_ngrants", 32'(gtimes.size()), 32'd5);
        if (gtimes.size() == 5)
            for (int i = 1; i < 5; i++)
                chk("rr_spacing", 32'(gtimes[i] - gtimes[i-1]), 32'd4);

        // Wrap-around after owner 2
        wdata = 32'h00220000;
        push(2, 8'h22);
        req = 4'b0100;
        wait_grants(1, 20);
        req = '0;
        repeat (5) tick();
        chk("owner_keep2", 32'(owner), 32'd2);
        wdata = 32'h00520050;
        push(0, 8'h50);
        push(2, 8'h52);
        req = 4'b0101;
        wait_grants(2, 30);
        req = '0;
        repeat (6) tick();

        // Request dropped during GRANT still writes
        wdata = 32'h00003C00;
        push(1, 8'h3C);
        req = 4'b0010;
        wait_gnt(20);
        req = '0;
        repeat (5) tick();
        chk("drop_q", 32'(q), 32'h3C);

        // Reset mid-HOLD clears outputs immediately
        wdata = 32'h000000FF;
        push(0, 8'hFF);
        req = 4'b0001;
        wait_gnt(20);
        req = '0;
        repeat (2) tick();
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("arst_q", 32'(q), 32'd0);
        chk("arst_gnt", 32'(gnt), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_owner", 32'(owner), 32'd0);
        sb.delete();
        repeat (2) tick();
        rst = 1'b1;
        wdata = 32'h77000000;
        push(3, 8'h77);
        req = 4'b1000;
        wait_grants(1, 20);
        req = '0;
        repeat (5) tick();
        chk("post_rst_owner", 32'(owner), 32'd3);

        // Reset in GRANT aborts the pending write
        wdata = 32'h00990000;
        push(2, 8'h99);
        req = 4'b0100;
        wait_gnt(20);
        req = '0;
        rst = 1'b0;
        #1;
        chk("abort_q", 32'(q), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        sb.delete();
        repeat (2) tick();
        rst = 1'b1;
        repeat (5) tick();
        chk("abort_q_after", 32'(q), 32'd0);

        // Random soak
        rnd = 1;
        hold_cnt = 0;
        for (int c = 0; c < 10000; c++) begin
            if (hold_cnt == 0) begin
                req      = NREQ'($urandom);
                hold_cnt = $urandom_range(1, 12);
            end
            hold_cnt--;
            wdata = $urandom;
            tick();
        end
        req = '0;
        repeat (8) tick();
        rnd = 0;
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
